// File: rtl/reconfig_pe.sv
// Reconfigurable systolic PE supporting output-, weight- and input-stationary dataflows.
// Define RECONFIG_PE_SAT_EN to saturate every accumulate/add instead of wrapping.
module reconfig_pe #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic [CNT_WIDTH-1:0]          k_len,
  input  logic                          start,
  input  logic                          preload,
  input  logic signed [DATA_WIDTH-1:0]  ifmap_in,
  input  logic                          ifmap_vld_in,
  input  logic signed [DATA_WIDTH-1:0]  weight_in,
  input  logic                          weight_vld_in,
  input  logic signed [ACCUM_WIDTH-1:0] psum_in_v,
  input  logic signed [ACCUM_WIDTH-1:0] psum_in_h,
  input  logic                          psum_vld_in,
  output logic signed [DATA_WIDTH-1:0]  ifmap_out,
  output logic                          ifmap_vld_out,
  output logic signed [DATA_WIDTH-1:0]  weight_out,
  output logic                          weight_vld_out,
  output logic signed [ACCUM_WIDTH-1:0] psum_out_v,
  output logic signed [ACCUM_WIDTH-1:0] psum_out_h,
  output logic                          psum_vld_out,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  localparam logic [1:0] M_OS = 2'b00;
  localparam logic [1:0] M_WS = 2'b01;
  localparam logic [1:0] M_IS = 2'b10;
  localparam logic [1:0] M_RS = 2'b11;

  state_t                         state;
  logic [1:0]                     mode_r;
  logic [CNT_WIDTH-1:0]           k_r;
  logic [CNT_WIDTH-1:0]           cnt;
  logic [CNT_WIDTH-1:0]           cnt_inc;
  logic signed [ACCUM_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0]   stat_reg;

  logic signed [DATA_WIDTH-1:0]   op_a, op_b;
  logic signed [ACCUM_WIDTH-1:0]  base_p0;
  logic signed [2*DATA_WIDTH-1:0] prod_p0;
  logic signed [ACCUM_WIDTH-1:0]  prod_ext_p0;
  logic signed [ACCUM_WIDTH-1:0]  sum_p0;
  logic                           mac_evt;

  function automatic logic signed [ACCUM_WIDTH-1:0] acc_add(
    input logic signed [ACCUM_WIDTH-1:0] a,
    input logic signed [ACCUM_WIDTH-1:0] b
  );
    logic [ACCUM_WIDTH:0] s;
    s = {a[ACCUM_WIDTH-1], a} + {b[ACCUM_WIDTH-1], b};
`ifdef RECONFIG_PE_SAT_EN
    // Sign bits disagree only on overflow; clamp toward the overflow direction.
    if (s[ACCUM_WIDTH] != s[ACCUM_WIDTH-1])
      return s[ACCUM_WIDTH] ? {1'b1, {(ACCUM_WIDTH-1){1'b0}}} : {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
`endif
    return s[ACCUM_WIDTH-1:0];
  endfunction

  // One shared multiplier; operand and addend selection follow the latched dataflow.
  always_comb begin
    op_a    = ifmap_in;
    op_b    = weight_in;
    base_p0 = acc;
    mac_evt = ifmap_vld_in & weight_vld_in;
    case (mode_r)
      M_WS: begin
        op_b    = stat_reg;
        base_p0 = psum_in_h;
        mac_evt = ifmap_vld_in & psum_vld_in;
      end
      M_IS: begin
        op_a    = weight_in;
        op_b    = stat_reg;
        base_p0 = psum_in_h;
        mac_evt = weight_vld_in & psum_vld_in;
      end
      default: ;
    endcase
  end

  assign prod_p0     = (2*DATA_WIDTH)'(op_a) * (2*DATA_WIDTH)'(op_b);
  assign prod_ext_p0 = {{(ACCUM_WIDTH-2*DATA_WIDTH){prod_p0[2*DATA_WIDTH-1]}}, prod_p0};
  assign sum_p0      = acc_add(base_p0, prod_ext_p0);
  assign cnt_inc     = cnt + CNT_WIDTH'(1);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mode_r         <= M_OS;
      k_r            <= '0;
      cnt            <= '0;
      acc            <= '0;
      stat_reg       <= '0;
      ifmap_out      <= '0;
      ifmap_vld_out  <= 1'b0;
      weight_out     <= '0;
      weight_vld_out <= 1'b0;
      psum_out_v     <= '0;
      psum_out_h     <= '0;
      psum_vld_out   <= 1'b0;
      done           <= 1'b0;
    end else begin
      ifmap_out      <= ifmap_in;
      ifmap_vld_out  <= ifmap_vld_in;
      weight_out     <= weight_in;
      weight_vld_out <= weight_vld_in;
      psum_vld_out   <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (start && mode != M_RS) begin
            mode_r <= mode;
            k_r    <= k_len;
            cnt    <= '0;
            if (mode == M_OS) begin
              acc        <= '0;
              psum_out_h <= '0;
              // An empty OS tile drains straight away with a zero result.
              if (k_len == '0) begin
                psum_out_v   <= '0;
                psum_vld_out <= 1'b1;
                state        <= DRAIN;
              end else begin
                state <= COMPUTE;
              end
            end else begin
              psum_out_v <= '0;
              state      <= LOAD;
            end
          end else if (mode_r == M_OS && psum_vld_in) begin
            psum_out_v   <= psum_in_v;
            psum_vld_out <= 1'b1;
          end
        end
        LOAD: begin
          if (preload) begin
            stat_reg <= (mode_r == M_WS) ? weight_in : ifmap_in;
            if (k_r == '0) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (mac_evt) begin
            cnt <= cnt_inc;
            if (mode_r == M_OS) begin
              acc <= sum_p0;
              // The final sum is presented during DRAIN; done follows one cycle later.
              if (cnt_inc == k_r) begin
                psum_out_v   <= sum_p0;
                psum_vld_out <= 1'b1;
                state        <= DRAIN;
              end
            end else begin
              psum_out_h   <= sum_p0;
              psum_vld_out <= 1'b1;
              if (cnt_inc == k_r) begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        DRAIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reconfig_pe.sv
// Directed bench for reconfig_pe: scoreboarded psum outputs plus inline control checks.
module tb_reconfig_pe;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           mode = 2'b00;
  logic [CW-1:0]        k_len = '0;
  logic                 start = 1'b0;
  logic                 preload = 1'b0;
  logic signed [DW-1:0] ifmap_in = '0;
  logic                 ifmap_vld_in = 1'b0;
  logic signed [DW-1:0] weight_in = '0;
  logic                 weight_vld_in = 1'b0;
  logic signed [AW-1:0] psum_in_v = '0;
  logic signed [AW-1:0] psum_in_h = '0;
  logic                 psum_vld_in = 1'b0;
  logic signed [DW-1:0] ifmap_out;
  logic                 ifmap_vld_out;
  logic signed [DW-1:0] weight_out;
  logic                 weight_vld_out;
  logic signed [AW-1:0] psum_out_v;
  logic signed [AW-1:0] psum_out_h;
  logic                 psum_vld_out;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int failures = 0;

  bit                   q_isv[$];
  logic signed [AW-1:0] q_val[$];

  reconfig_pe #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .k_len(k_len), .start(start), .preload(preload),
    .ifmap_in(ifmap_in), .ifmap_vld_in(ifmap_vld_in),
    .weight_in(weight_in), .weight_vld_in(weight_vld_in),
    .psum_in_v(psum_in_v), .psum_in_h(psum_in_h), .psum_vld_in(psum_vld_in),
    .ifmap_out(ifmap_out), .ifmap_vld_out(ifmap_vld_out),
    .weight_out(weight_out), .weight_vld_out(weight_vld_out),
    .psum_out_v(psum_out_v), .psum_out_h(psum_out_h), .psum_vld_out(psum_vld_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit isv, input logic signed [AW-1:0] v);
    q_isv.push_back(isv);
    q_val.push_back(v);
  endtask

  // Reference add: exact sum then saturate or wrap to 32 bits.
  function automatic logic signed [AW-1:0] model_mac(input longint base, input longint a, input longint b);
    longint s;
    s = base + a * b;
`ifdef RECONFIG_PE_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[AW-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && psum_vld_out === 1'b1) begin
      if (q_val.size() == 0) begin
        check("psum_unexpected_vld", longint'(psum_vld_out), 0);
      end else begin
        bit isv;
        logic signed [AW-1:0] v;
        isv = q_isv.pop_front();
        v   = q_val.pop_front();
        if (isv) begin
          check("psum_out_v", longint'(psum_out_v), longint'(v));
          check("psum_out_h_unused", longint'(psum_out_h), 0);
        end else begin
          check("psum_out_h", longint'(psum_out_h), longint'(v));
          check("psum_out_v_unused", longint'(psum_out_v), 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] exp34;
    int a_os[3] = '{2, -4, 7};
    int b_os[3] = '{3, 5, -1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_psum_vld", longint'(psum_vld_out), 0);
    check("rst_psum_v", longint'(psum_out_v), 0);
    check("rst_psum_h", longint'(psum_out_h), 0);
    rst = 1'b0;
    step();

    // Systolic pass-through
    ifmap_in = 8'sd5; ifmap_vld_in = 1'b1; weight_in = -8'sd2; weight_vld_in = 1'b1;
    step();
    check("pass_ifmap", longint'(ifmap_out), 5);
    check("pass_ifmap_vld", longint'(ifmap_vld_out), 1);
    check("pass_weight", longint'(weight_out), -2);
    check("pass_weight_vld", longint'(weight_vld_out), 1);
    ifmap_vld_in = 1'b0; weight_vld_in = 1'b0;

    // Reserved mode start ignored
    mode = 2'b11; k_len = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("reserved_busy", longint'(busy), 0);

    // OS tile k=3 -> -21
    mode = 2'b00; k_len = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("os_busy", longint'(busy), 1);
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      ifmap_in = DW'(a_os[i]); weight_in = DW'(b_os[i]);
      ifmap_vld_in = 1'b1; weight_vld_in = 1'b1;
      acc = model_mac(longint'(acc), a_os[i], b_os[i]);
      if (i == 2) push(1'b1, acc);
      step();
    end
    ifmap_vld_in = 1'b0; weight_vld_in = 1'b0;
    check("os_model_value", longint'(acc), -21);
    check("os_done_in_drain", longint'(done), 0);
    step();
    check("os_done", longint'(done), 1);
    check("os_busy_after", longint'(busy), 0);
    step();
    check("os_done_single", longint'(done), 0);

    // IDLE column forwarding with latched OS
    psum_in_v = 32'sd1234; psum_vld_in = 1'b1;
    push(1'b1, 32'sd1234);
    step();
    psum_vld_in = 1'b0;
    step();

    // WS: weight -3, ifmap 4, psum 100 -> 88
    mode = 2'b01; k_len = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("ws_load_busy", longint'(busy), 1);
    preload = 1'b1; weight_in = -8'sd3;
    step();
    preload = 1'b0; weight_in = 8'sd0;
    ifmap_in = 8'sd4; ifmap_vld_in = 1'b1; psum_in_h = 32'sd100; psum_vld_in = 1'b1;
    push(1'b0, model_mac(100, 4, -3));
    step();
    ifmap_vld_in = 1'b0; psum_vld_in = 1'b0;
    check("ws_done", longint'(done), 1);
    check("ws_busy_after", longint'(busy), 0);

    // IS: stat 5, one non-qualifying cycle, then two MACs
    mode = 2'b10; k_len = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    preload = 1'b1; ifmap_in = 8'sd5;
    step();
    preload = 1'b0;
    ifmap_vld_in = 1'b1; psum_vld_in = 1'b1; psum_in_h = 32'sd999;
    step();
    ifmap_vld_in = 1'b0;
    weight_in = 8'sd6; weight_vld_in = 1'b1; psum_in_h = 32'sd10;
    push(1'b0, model_mac(10, 6, 5));
    step();
    check("is_done_early", longint'(done), 0);
    check("is_busy_mid", longint'(busy), 1);
    weight_in = -8'sd7; psum_in_h = 32'sd1;
    push(1'b0, model_mac(1, -7, 5));
    step();
    weight_vld_in = 1'b0; psum_vld_in = 1'b0;
    check("is_done", longint'(done), 1);

    // WS overflow boundary
`ifdef RECONFIG_PE_SAT_EN
    exp34 = 32'h7FFF_FFFF;
`else
    exp34 = 32'h8000_3EF1;
`endif
    mode = 2'b01; k_len = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    preload = 1'b1; weight_in = 8'sd127;
    step();
    preload = 1'b0;
    ifmap_in = 8'sd127; ifmap_vld_in = 1'b1; psum_in_h = 32'h7FFF_FFF0; psum_vld_in = 1'b1;
    push(1'b0, exp34);
    step();
    ifmap_vld_in = 1'b0; psum_vld_in = 1'b0;
    check("ws_ovf_done", longint'(done), 1);

    // WS k=0: done right after preload
    mode = 2'b01; k_len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("ws_k0_no_done_load", longint'(done), 0);
    preload = 1'b1;
    step();
    preload = 1'b0;
    check("ws_k0_done", longint'(done), 1);
    check("ws_k0_busy", longint'(busy), 0);

    // Start re-asserted mid-tile is ignored
    mode = 2'b00; k_len = 8'd2; start = 1'b1;
    step();
    mode = 2'b01; k_len = 8'd5;
    ifmap_in = 8'sd1; weight_in = 8'sd2; ifmap_vld_in = 1'b1; weight_vld_in = 1'b1;
    step();
    start = 1'b0; mode = 2'b00;
    ifmap_in = 8'sd3; weight_in = 8'sd4;
    push(1'b1, model_mac(model_mac(0, 1, 2), 3, 4));
    step();
    ifmap_vld_in = 1'b0; weight_vld_in = 1'b0;
    step();
    check("restart_done", longint'(done), 1);

    // OS k=0 drains zero
    mode = 2'b00; k_len = 8'd0; start = 1'b1;
    push(1'b1, 32'sd0);
    step();
    start = 1'b0;
    check("os_k0_busy", longint'(busy), 1);
    step();
    check("os_k0_done", longint'(done), 1);

    // Reset mid-COMPUTE, then cold-start an OS tile
    mode = 2'b00; k_len = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    ifmap_in = 8'sd3; weight_in = 8'sd3; ifmap_vld_in = 1'b1; weight_vld_in = 1'b1;
    step();
    ifmap_in = 8'sd2; weight_in = 8'sd2;
    step();
    ifmap_vld_in = 1'b0; weight_vld_in = 1'b0;
    check("pre_rst_busy", longint'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_ifmap_out", longint'(ifmap_out), 0);
    check("mid_rst_weight_out", longint'(weight_out), 0);
    check("mid_rst_psum_vld", longint'(psum_vld_out), 0);
    check("mid_rst_done", longint'(done), 0);
    #1 rst = 1'b0;
    step();
    mode = 2'b00; k_len = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    ifmap_in = 8'sd1; weight_in = 8'sd1; ifmap_vld_in = 1'b1; weight_vld_in = 1'b1;
    push(1'b1, model_mac(0, 1, 1));
    step();
    ifmap_vld_in = 1'b0; weight_vld_in = 1'b0;
    step();
    check("post_rst_done", longint'(done), 1);

    repeat (3) step();
    check("scoreboard_drained", longint'(q_val.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
